// File: rtl/lcd_pkg.sv
// Shared types and constants for the character-LCD controller.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_PWRUP,
    ST_INIT_LOAD,
    ST_SETUP,
    ST_EN_HI,
    ST_HOLD,
    ST_WAIT,
    ST_IDLE
  } lcd_state_e;

  // lcd_reg bit positions
  localparam int LCD_ON_BIT  = 31;
  localparam int REQ_TGL_BIT = 30;
  localparam int RS_BIT      = 8;

  // lcd_status bit positions
  localparam int BUSY_BIT      = 0;
  localparam int INIT_DONE_BIT = 1;
  localparam int ACK_TGL_BIT   = 30;

  // HD44780 init: 8-bit/2-line, display on, clear, entry mode (index 0 first)
  localparam logic [3:0][7:0] INIT_ROM = {8'h06, 8'h01, 8'h0C, 8'h38};

  // Clear display / return home need the long execution wait
  function automatic logic is_long_cmd(logic rs, logic [7:0] data);
    return !rs && (data[7:2] == 6'd0);
  endfunction

  function automatic int unsigned max_u(int unsigned a, int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd_phase_timer.sv
// Shared phase down-counter: loaded with (T-1) on phase entry, done at zero.
module lcd_phase_timer #(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          load_i,
  input  logic [CW-1:0] load_val_i,
  output logic          done_o
);

  logic [CW-1:0] cnt_q;

  // Reload on phase entry, otherwise count down and park at zero
  always_ff @(posedge clk) begin
    if (load_i)             cnt_q <= load_val_i;
    else if (cnt_q != '0)   cnt_q <= cnt_q - 1'b1;
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/lcd_ctrl.sv
// HD44780 character-LCD controller: power-up init, then timed CPU byte writes
// via a toggle handshake on the memory-mapped lcd register.
module lcd_ctrl
  import lcd_pkg::*;
#(
  parameter int unsigned T_PWRUP = 750_000,
  parameter int unsigned T_AS    = 4,
  parameter int unsigned T_EN    = 16,
  parameter int unsigned T_H     = 4,
  parameter int unsigned T_CMD   = 2_000,
  parameter int unsigned T_LONG  = 82_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] lcd_reg,
  output logic [31:0] lcd_status,
  output logic [7:0]  lcd_data,
  output logic        lcd_rs,
  output logic        lcd_rw,
  output logic        lcd_en,
  output logic        lcd_on
);

  localparam int unsigned TMAX = max_u(max_u(max_u(T_PWRUP, T_AS), max_u(T_EN, T_H)),
                                       max_u(T_CMD, T_LONG));
  localparam int CW = $clog2(TMAX) + 1;

  if (T_PWRUP < 1 || T_AS < 1 || T_EN < 1 || T_H < 1 || T_CMD < 1 || T_LONG < 1) begin : g_param_chk
    $error("lcd_ctrl: every timing parameter must be at least 1");
  end

  lcd_state_e    state_q, state_d;
  logic [1:0]    idx_q;
  logic          init_done_q, ack_q, req_q;
  logic          rs_q, en_q, on_q;
  logic [7:0]    data_q;
  logic          ld;
  logic [CW-1:0] ld_val;
  logic          t_done;
  logic          pending;

  // Unused lcd_reg bits are ignored by design
  logic unused_lcd_reg;
  assign unused_lcd_reg = ^lcd_reg[29:9];

  assign pending = (lcd_reg[REQ_TGL_BIT] != ack_q);

  lcd_phase_timer #(.CW(CW)) u_timer (
    .clk       (clk),
    .load_i    (ld),
    .load_val_i(ld_val),
    .done_o    (t_done)
  );

  // Next state and timer reload; the reload fires on the edge that enters a phase
  always_comb begin
    state_d = state_q;
    ld      = 1'b0;
    ld_val  = '0;
    if (!rst) begin
      state_d = ST_PWRUP;
      ld      = 1'b1;
      ld_val  = CW'(T_PWRUP - 1);
    end else begin
      case (state_q)
        ST_PWRUP:     if (t_done) state_d = ST_INIT_LOAD;
        ST_INIT_LOAD: begin
          state_d = ST_SETUP;
          ld      = 1'b1;
          ld_val  = CW'(T_AS - 1);
        end
        ST_SETUP: if (t_done) begin
          state_d = ST_EN_HI;
          ld      = 1'b1;
          ld_val  = CW'(T_EN - 1);
        end
        ST_EN_HI: if (t_done) begin
          state_d = ST_HOLD;
          ld      = 1'b1;
          ld_val  = CW'(T_H - 1);
        end
        ST_HOLD: if (t_done) begin
          state_d = ST_WAIT;
          ld      = 1'b1;
          ld_val  = is_long_cmd(rs_q, data_q) ? CW'(T_LONG - 1) : CW'(T_CMD - 1);
        end
        ST_WAIT: if (t_done) begin
          state_d = (!init_done_q && idx_q != 2'd3) ? ST_INIT_LOAD : ST_IDLE;
        end
        ST_IDLE: if (pending) begin
          state_d = ST_SETUP;
          ld      = 1'b1;
          ld_val  = CW'(T_AS - 1);
        end
        default: state_d = ST_PWRUP;
      endcase
    end
  end

  // State register, pin registers, request latch, init index and handshake
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_PWRUP;
      idx_q       <= 2'd0;
      init_done_q <= 1'b0;
      ack_q       <= 1'b0;
      req_q       <= 1'b0;
      rs_q        <= 1'b0;
      data_q      <= 8'h00;
      en_q        <= 1'b0;
      on_q        <= 1'b0;
    end else begin
      state_q <= state_d;
      on_q    <= lcd_reg[LCD_ON_BIT];
      case (state_q)
        ST_INIT_LOAD: begin
          rs_q   <= 1'b0;
          data_q <= INIT_ROM[idx_q];
        end
        ST_IDLE: if (pending) begin
          rs_q   <= lcd_reg[RS_BIT];
          data_q <= lcd_reg[7:0];
          req_q  <= lcd_reg[REQ_TGL_BIT];
        end
        ST_SETUP: if (t_done) en_q <= 1'b1;
        ST_EN_HI: if (t_done) en_q <= 1'b0;
        ST_WAIT: if (t_done) begin
          if (init_done_q)       ack_q       <= req_q;
          else if (idx_q == 2'd3) init_done_q <= 1'b1;
          else                   idx_q       <= idx_q + 2'd1;
        end
        default: ;
      endcase
    end
  end

  // Status word for the LSU load path
  always_comb begin
    lcd_status                = '0;
    lcd_status[BUSY_BIT]      = (state_q != ST_IDLE);
    lcd_status[INIT_DONE_BIT] = init_done_q;
    lcd_status[ACK_TGL_BIT]   = ack_q;
  end

  assign lcd_data = data_q;
  assign lcd_rs   = rs_q;
  assign lcd_rw   = 1'b0;
  assign lcd_en   = en_q;
  assign lcd_on   = on_q;

endmodule

// File: tb/tb_lcd_ctrl.sv
// Bench for lcd_ctrl: timeline model checked every cycle plus directed literal checks.
module tb_lcd_ctrl;

  localparam int T_PWRUP = 20, T_AS = 2, T_EN = 4, T_H = 2, T_CMD = 10, T_LONG = 50;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] lcd_reg = '0;
  logic [31:0] lcd_status;
  logic [7:0]  lcd_data;
  logic        lcd_rs, lcd_rw, lcd_en, lcd_on;

  lcd_ctrl #(
    .T_PWRUP(T_PWRUP), .T_AS(T_AS), .T_EN(T_EN), .T_H(T_H), .T_CMD(T_CMD), .T_LONG(T_LONG)
  ) dut (
    .clk(clk), .rst(rst), .lcd_reg(lcd_reg), .lcd_status(lcd_status),
    .lcd_data(lcd_data), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_en(lcd_en), .lcd_on(lcd_on)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- timeline model ----------------
  // A command starting at edge s: EN high for edges-since-start in [T_AS, T_AS+T_EN),
  // finished at s + T_AS+T_EN+T_H+wait.
  localparam int M_PWR = 0, M_GAP = 1, M_CMD = 2, M_IDLE = 3;
  int          rom [4] = '{'h38, 'h0C, 'h01, 'h06};
  bit          mvalid = 1'b0;
  int          e = 0, ms = 0, mmode = M_PWR, midx = 0;
  bit          mdone, mack, mreq, mrs, mon, men;
  int          mdata;
  logic [31:0] mstatus;
  logic        en_prev = 1'b0;
  int          npulse = 0;
  logic [7:0]  pdata[$];

  function automatic int cmd_len(bit rs, int data);
    return T_AS + T_EN + T_H + ((rs == 1'b0 && data < 4) ? T_LONG : T_CMD);
  endfunction

  always begin
    @(posedge clk);
    e++;
    if (!rst) begin
      mvalid = 1'b1; mmode = M_PWR; ms = e; midx = 0;
      mdone = 0; mack = 0; mreq = 0; mrs = 0; mdata = 0; mon = 0;
    end else if (mvalid) begin
      mon = lcd_reg[31];
      case (mmode)
        M_PWR: if (e - ms == T_PWRUP) mmode = M_GAP;
        M_GAP: begin mmode = M_CMD; ms = e; mrs = 0; mdata = rom[midx]; end
        M_CMD: if (e - ms == cmd_len(mrs, mdata)) begin
          if (mdone) begin mack = mreq; mmode = M_IDLE; end
          else if (midx == 3) begin mdone = 1; mmode = M_IDLE; end
          else begin midx++; mmode = M_GAP; end
        end
        default: if (lcd_reg[30] != mack) begin
          mmode = M_CMD; ms = e; mrs = lcd_reg[8]; mdata = int'(lcd_reg[7:0]); mreq = lcd_reg[30];
        end
      endcase
    end
    men     = (mmode == M_CMD) && (e - ms >= T_AS) && (e - ms < T_AS + T_EN);
    mstatus = {1'b0, mack, 28'd0, mdone, (mmode != M_IDLE)};
    #1;
    if (mvalid) begin
      check("cyc lcd_en", lcd_en, men);
      check("cyc lcd_rs", lcd_rs, mrs);
      check("cyc lcd_data", lcd_data, mdata[7:0]);
      check("cyc lcd_status", lcd_status, mstatus);
      check("cyc lcd_on", lcd_on, mon);
      check("cyc lcd_rw", lcd_rw, 1'b0);
    end
    if (lcd_en === 1'b1 && en_prev !== 1'b1) begin
      npulse++;
      pdata.push_back(lcd_data);
    end
    en_prev = lcd_en;
  end

  // ---------------- stimulus helpers ----------------
  bit req_b = 1'b0;
  bit on_b  = 1'b0;

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_write(bit rs, logic [7:0] data);
    req_b   = ~req_b;
    lcd_reg = {on_b, req_b, 21'd0, rs, data};
  endtask

  task automatic wait_en_hi(string name);
    int c = 0;
    while (lcd_en !== 1'b1 && c < 500) begin @(negedge clk); c++; end
    if (c >= 500) check(name, lcd_en, 1'b1);
  endtask

  task automatic count_en_low(string name, output int n);
    n = 0;
    while (lcd_en !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
    if (n >= 1000) check(name, lcd_en, 1'b1);
  endtask

  task automatic wait_idle(string name, int budget);
    int c = 0;
    while (lcd_status[0] !== 1'b0 && c < budget) begin @(negedge clk); c++; end
    if (c >= budget) check(name, lcd_status[0], 1'b0);
  endtask

  // Call right after a write at a negedge: counts cycles with BUSY=1
  task automatic busy_len(string name, output int n);
    n = 0;
    @(negedge clk);
    while (lcd_status[0] === 1'b1 && n < 2000) begin n++; @(negedge clk); end
    if (n >= 2000) check(name, lcd_status[0], 1'b0);
  endtask

  task automatic init_seq(string tag);
    int n, p0;
    p0 = npulse;
    count_en_low({tag, " en low before first pulse"}, n);
    // power-up wait + INIT_LOAD cycle + setup
    check({tag, " en low cycles"}, n, 23);
    wait_idle({tag, " init timeout"}, 1000);
    check({tag, " init pulses"}, npulse - p0, 4);
    check({tag, " status after init"}, lcd_status, 32'h0000_0002);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, p0;
    // 1: reset and power-up init
    tick(3);
    check("reset status", lcd_status, 32'h0000_0001);
    check("reset lcd_en", lcd_en, 1'b0);
    check("reset lcd_on", lcd_on, 1'b0);
    rst = 1'b1;
    init_seq("t1");
    check("init cmd0", pdata[0], 8'h38);
    check("init cmd1", pdata[1], 8'h0C);
    check("init cmd2", pdata[2], 8'h01);
    check("init cmd3", pdata[3], 8'h06);

    // 2: data write 'A'
    p0 = npulse;
    do_write(1'b1, 8'h41);
    check("t2 lcd_reg vector", lcd_reg, 32'h4000_0141);
    busy_len("t2 busy", n);
    check("t2 busy cycles", n, 18);
    check("t2 status", lcd_status, 32'h4000_0002);
    check("t2 pulses", npulse - p0, 1);
    check("t2 rs", lcd_rs, 1'b1);
    check("t2 data", lcd_data, 8'h41);

    // 3: clear (long wait) vs set-DDRAM (normal wait)
    do_write(1'b0, 8'h01);
    busy_len("t3 clear busy", n);
    check("t3 clear busy cycles", n, 58);
    do_write(1'b0, 8'h80);
    busy_len("t3 ddram busy", n);
    check("t3 ddram busy cycles", n, 18);

    // 4a: second request made during EN_HI is served right after the ack
    p0 = npulse;
    do_write(1'b1, 8'h41);
    wait_en_hi("t4 first en");
    do_write(1'b1, 8'h42);
    wait_idle("t4 first ack", 200);
    n = 0;
    while (lcd_status[0] === 1'b0 && n < 50) begin n++; @(negedge clk); end
    check("t4 idle gap", n, 1);
    wait_idle("t4 second ack", 200);
    tick(3);
    check("t4 pulses", npulse - p0, 2);
    check("t4 last data", pdata[pdata.size()-1], 8'h42);

    // 4b: two flips while busy cancel out
    p0 = npulse;
    do_write(1'b1, 8'h43);
    wait_en_hi("t4b en");
    do_write(1'b1, 8'h43);
    tick(2);
    do_write(1'b1, 8'h43);
    wait_idle("t4b ack", 200);
    tick(5);
    check("t4b pulses", npulse - p0, 1);
    check("t4b status", lcd_status, {1'b0, req_b, 30'h2});

    // 6: reset during EN_HI, then full re-init
    do_write(1'b1, 8'h44);
    wait_en_hi("t6 en");
    rst = 1'b0; req_b = 1'b0; lcd_reg = '0;
    @(negedge clk);
    check("t6 en dropped", lcd_en, 1'b0);
    check("t6 status", lcd_status, 32'h0000_0001);
    tick(2);
    rst = 1'b1;
    init_seq("t6");

    // 5: request pending across reset release, lcd_on during PWRUP
    rst = 1'b0; on_b = 1'b1; req_b = 1'b1;
    lcd_reg = {on_b, req_b, 30'd0};
    @(negedge clk);
    check("t5 lcd_on in reset", lcd_on, 1'b0);
    tick(1);
    rst = 1'b1;
    p0 = npulse;
    @(negedge clk);
    check("t5 lcd_on pwrup", lcd_on, 1'b1);
    check("t5 status pwrup", lcd_status, 32'h0000_0001);
    n = 0;
    while (lcd_status[30] !== 1'b1 && n < 2000) begin n++; @(negedge clk); end
    if (n >= 2000) check("t5 ack timeout", lcd_status[30], 1'b1);
    tick(5);
    check("t5 pulses", npulse - p0, 5);
    check("t5 served data", pdata[pdata.size()-1], 8'h00);
    check("t5 status", lcd_status, 32'h4000_0002);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
